// File: rtl/frame_buffer_writer_if.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_writer_if
//  Description : Command handshake and frame-buffer write-port bundle.
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_buffer_writer_if;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic [1:0]  CMD_OP;
   logic [7:0]  CMD_X0;
   logic [6:0]  CMD_Y0;
   logic [7:0]  CMD_X1;
   logic [6:0]  CMD_Y1;
   logic        CMD_COLOUR;
   logic [14:0] FB_ADDR;
   logic        FB_DATA;
   logic        FB_WE;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   // master: the writer itself; slave: the command issuer / observer
   modport master (
      input  CMD_VALID, CMD_OP, CMD_X0, CMD_Y0, CMD_X1, CMD_Y1, CMD_COLOUR,
      output CMD_READY, FB_ADDR, FB_DATA, FB_WE, BUSY, DONE, ERR
   );

   modport slave (
      output CMD_VALID, CMD_OP, CMD_X0, CMD_Y0, CMD_X1, CMD_Y1, CMD_COLOUR,
      input  CMD_READY, FB_ADDR, FB_DATA, FB_WE, BUSY, DONE, ERR
   );
endinterface
`default_nettype wire

// File: rtl/frame_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : frame_buffer_writer
//  Description : Rasterises PIXEL / RECT / CLEAR commands into one 1-bit
//                frame-buffer write per clock, address {Y[6:0], X[7:0]}.
//  Revision    : 1.0  initial release
// ============================================================================
module frame_buffer_writer #(
   parameter int   FB_WIDTH    = 160,
   parameter int   FB_HEIGHT   = 120,
   parameter logic CLEAR_VALUE = 1'b0
) (
   input  wire logic             CLK,
   input  wire logic             RESET,
   frame_buffer_writer_if.master bus
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_DRAW  = 2'd1;
   localparam logic [1:0] c_ST_FIN   = 2'd2;

   localparam logic [1:0] c_OP_PIXEL = 2'b00;
   localparam logic [1:0] c_OP_RECT  = 2'b01;
   localparam logic [1:0] c_OP_CLEAR = 2'b10;

   localparam logic [7:0] c_X_MAX = 8'(FB_WIDTH - 1);
   localparam logic [6:0] c_Y_MAX = 7'(FB_HEIGHT - 1);

   logic [1:0] r_state;
   logic [7:0] r_x;
   logic [7:0] r_x_lo;
   logic [7:0] r_x_hi;
   logic [6:0] r_y;
   logic [6:0] r_y_hi;
   logic       r_colour;
   logic       r_err;

   logic       w_accept;
   logic       w_reject;
   logic       w_colour;
   logic [7:0] w_x0;
   logic [7:0] w_x1;
   logic [6:0] w_y0;
   logic [6:0] w_y1;

   function automatic logic [7:0] clip_x(input logic [7:0] v);
      return (v > c_X_MAX) ? c_X_MAX : v;
   endfunction

   function automatic logic [6:0] clip_y(input logic [6:0] v);
      return (v > c_Y_MAX) ? c_Y_MAX : v;
   endfunction

   assign w_accept = bus.CMD_VALID && bus.CMD_READY;

   // Bounds are clipped first, then the ordering check decides rejection.
   always_comb begin
      w_x0     = clip_x(bus.CMD_X0);
      w_y0     = clip_y(bus.CMD_Y0);
      w_x1     = clip_x(bus.CMD_X1);
      w_y1     = clip_y(bus.CMD_Y1);
      w_colour = bus.CMD_COLOUR;
      w_reject = 1'b0;
      case (bus.CMD_OP)
         c_OP_PIXEL: begin
            w_x1 = w_x0;
            w_y1 = w_y0;
         end
         c_OP_RECT: begin
            w_reject = (w_x0 > w_x1) || (w_y0 > w_y1);
         end
         c_OP_CLEAR: begin
            w_x0     = 8'd0;
            w_y0     = 7'd0;
            w_x1     = c_X_MAX;
            w_y1     = c_Y_MAX;
            w_colour = CLEAR_VALUE;
         end
         default: begin
            w_reject = 1'b1;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state  <= c_ST_IDLE;
         r_x      <= 8'd0;
         r_x_lo   <= 8'd0;
         r_x_hi   <= 8'd0;
         r_y      <= 7'd0;
         r_y_hi   <= 7'd0;
         r_colour <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_err <= w_reject;
                  if (w_reject) begin
                     r_state <= c_ST_FIN;
                  end else begin
                     r_state  <= c_ST_DRAW;
                     r_x      <= w_x0;
                     r_y      <= w_y0;
                     r_x_lo   <= w_x0;
                     r_x_hi   <= w_x1;
                     r_y_hi   <= w_y1;
                     r_colour <= w_colour;
                  end
               end
            end
            c_ST_DRAW: begin
               // Counters park on the final pixel so the address holds afterwards.
               if (r_x != r_x_hi) begin
                  r_x <= r_x + 8'd1;
               end else if (r_y != r_y_hi) begin
                  r_x <= r_x_lo;
                  r_y <= r_y + 7'd1;
               end else begin
                  r_state <= c_ST_FIN;
               end
            end
            c_ST_FIN: begin
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign bus.CMD_READY = (r_state == c_ST_IDLE) && RESET;
   assign bus.FB_WE     = (r_state == c_ST_DRAW);
   assign bus.FB_ADDR   = {r_y, r_x};
   assign bus.FB_DATA   = r_colour;
   assign bus.BUSY      = (r_state != c_ST_IDLE);
   assign bus.DONE      = (r_state == c_ST_FIN) && !r_err;
   assign bus.ERR       = (r_state == c_ST_FIN) && r_err;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_buffer_writer
//  Description : Self-checking bench for frame_buffer_writer against a
//                raster-loop reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_buffer_writer;

   localparam int   W  = 160;
   localparam int   H  = 120;
   localparam logic CV = 1'b0;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   frame_buffer_writer_if bus ();

   frame_buffer_writer #(
      .FB_WIDTH    (W),
      .FB_HEIGHT   (H),
      .CLEAR_VALUE (CV)
   ) dut (
      .CLK   (clk),
      .RESET (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [14:0] exp_addr[$];
   logic        exp_data[$];
   bit          exp_err;

   logic [14:0] obs_addr[$];
   logic        obs_data[$];
   int          obs_done_k, obs_err_k, obs_done_cnt, obs_err_cnt, obs_gap, obs_hold_bad;
   bit          obs_ready, obs_timeout;
   logic [14:0] last_addr;
   logic        last_data;

   // Reference: clip, order-check, then plain nested raster loops.
   task automatic model_cmd(input logic [1:0] op, input int x0, input int y0,
                            input int x1, input int y1, input logic col);
      int xa, ya, xb, yb;
      logic d;
      exp_addr.delete();
      exp_data.delete();
      exp_err = 1'b0;
      d  = col;
      xa = x0; ya = y0; xb = x1; yb = y1;
      if (op == 2'd0) begin
         xb = x0; yb = y0;
      end else if (op == 2'd2) begin
         xa = 0; ya = 0; xb = W - 1; yb = H - 1; d = CV;
      end else if (op == 2'd3) begin
         exp_err = 1'b1;
      end
      if (xa >= W) xa = W - 1;
      if (xb >= W) xb = W - 1;
      if (ya >= H) ya = H - 1;
      if (yb >= H) yb = H - 1;
      if (xa > xb || ya > yb) exp_err = 1'b1;
      if (!exp_err) begin
         for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
               exp_addr.push_back(15'(y * 256 + x));
               exp_data.push_back(d);
            end
         end
      end
   endtask

   function automatic int first_diff();
      int bad = -1;
      if (obs_addr.size() == exp_addr.size()) begin
         for (int j = 0; j < exp_addr.size(); j++) begin
            if (bad < 0 && (obs_addr[j] !== exp_addr[j] || obs_data[j] !== exp_data[j]))
               bad = j;
         end
      end
      return bad;
   endfunction

   // Issues one command and records every observable up to the READY cycle.
   task automatic run_cmd(input logic [1:0] op, input logic [7:0] x0, input logic [6:0] y0,
                          input logic [7:0] x1, input logic [6:0] y1, input logic col);
      int k, w, stop_k, budget;
      obs_addr.delete();
      obs_data.delete();
      obs_done_k = 0; obs_err_k = 0; obs_done_cnt = 0; obs_err_cnt = 0;
      obs_gap = 0; obs_hold_bad = 0; obs_ready = 1'b0; obs_timeout = 1'b0;
      budget = exp_addr.size() + 10;
      @(negedge clk);
      w = 0;
      while (bus.CMD_READY !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (bus.CMD_READY !== 1'b1) begin
         obs_timeout = 1'b1;
      end else begin
         bus.CMD_VALID  = 1'b1;
         bus.CMD_OP     = op;
         bus.CMD_X0     = x0;
         bus.CMD_Y0     = y0;
         bus.CMD_X1     = x1;
         bus.CMD_Y1     = y1;
         bus.CMD_COLOUR = col;
         @(posedge clk);
         #1;
         bus.CMD_VALID  = 1'b0;
         bus.CMD_OP     = 2'($urandom);
         bus.CMD_X0     = 8'($urandom);
         bus.CMD_Y0     = 7'($urandom);
         bus.CMD_X1     = 8'($urandom);
         bus.CMD_Y1     = 7'($urandom);
         bus.CMD_COLOUR = 1'($urandom);
         stop_k = 0;
         for (k = 1; k <= budget; k++) begin
            if (k > 1) begin
               @(posedge clk);
               #1;
            end
            if (bus.FB_WE === 1'b1) begin
               if (obs_addr.size() != k - 1) obs_gap++;
               obs_addr.push_back(bus.FB_ADDR);
               obs_data.push_back(bus.FB_DATA);
               last_addr = bus.FB_ADDR;
               last_data = bus.FB_DATA;
            end else if (bus.FB_ADDR !== last_addr || bus.FB_DATA !== last_data) begin
               obs_hold_bad++;
            end
            if (bus.DONE === 1'b1) begin obs_done_cnt++; obs_done_k = k; end
            if (bus.ERR === 1'b1)  begin obs_err_cnt++;  obs_err_k  = k; end
            if (stop_k == 0 && (bus.DONE === 1'b1 || bus.ERR === 1'b1)) stop_k = k + 1;
            if (k == stop_k) begin
               obs_ready = (bus.CMD_READY === 1'b1);
               break;
            end
         end
         if (stop_k == 0 || k > budget) obs_timeout = 1'b1;
      end
   endtask

   task automatic test_reset();
      bus.CMD_VALID = 1'b0; bus.CMD_OP = 2'd0; bus.CMD_COLOUR = 1'b0;
      bus.CMD_X0 = 8'd0; bus.CMD_Y0 = 7'd0; bus.CMD_X1 = 8'd0; bus.CMD_Y1 = 7'd0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({bus.FB_WE, bus.FB_ADDR, bus.FB_DATA, bus.DONE, bus.ERR, bus.BUSY} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs: got we=%b addr=%h data=%b done=%b err=%b busy=%b required all 0",
                  bus.FB_WE, bus.FB_ADDR, bus.FB_DATA, bus.DONE, bus.ERR, bus.BUSY);
      end
      checks++;
      if (bus.CMD_READY !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready_low: got %b required 0", bus.CMD_READY);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.CMD_READY !== 1'b1 || bus.BUSY !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got ready=%b busy=%b required ready=1 busy=0", bus.CMD_READY, bus.BUSY);
      end
      last_addr = 15'd0;
      last_data = 1'b0;
   endtask

   task automatic test_pixel();
      model_cmd(2'd0, 10, 5, 0, 0, 1'b1);
      run_cmd(2'd0, 8'd10, 7'd5, 8'd77, 7'd3, 1'b1);
      checks++;
      if (obs_timeout || obs_addr.size() != 1 || obs_addr[0] !== 15'h050A || obs_data[0] !== 1'b1) begin
         errors++;
         $display("FAIL pixel_write: got n=%0d addr=%h required n=1 addr=050a data=1",
                  obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 15'h0);
      end
      checks++;
      if (obs_done_k != 2 || obs_done_cnt != 1 || obs_err_cnt != 0 || !obs_ready) begin
         errors++;
         $display("FAIL pixel_done: got done_k=%0d done_n=%0d err_n=%0d ready=%b required 2 1 0 1",
                  obs_done_k, obs_done_cnt, obs_err_cnt, obs_ready);
      end
   endtask

   task automatic test_rect_small();
      logic [14:0] want[4];
      bit ok;
      want = '{15'h0000, 15'h0001, 15'h0100, 15'h0101};
      model_cmd(2'd1, 0, 0, 1, 1, 1'b1);
      run_cmd(2'd1, 8'd0, 7'd0, 8'd1, 7'd1, 1'b1);
      ok = !obs_timeout && obs_addr.size() == 4 && obs_gap == 0;
      for (int j = 0; j < 4; j++)
         if (ok && (obs_addr[j] !== want[j] || obs_data[j] !== 1'b1)) ok = 1'b0;
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL rect2x2_writes: got n=%0d gaps=%0d required 4 writes 0000,0001,0100,0101",
                  obs_addr.size(), obs_gap);
      end
      checks++;
      if (obs_done_k != 5 || !obs_ready) begin
         errors++;
         $display("FAIL rect2x2_timing: got done_k=%0d ready_at_6=%b required 5 1", obs_done_k, obs_ready);
      end
   endtask

   task automatic test_clear();
      model_cmd(2'd2, 0, 0, 0, 0, 1'b1);
      run_cmd(2'd2, 8'd33, 7'd44, 8'd55, 7'd66, 1'b1);
      checks++;
      if (obs_timeout || obs_addr.size() != 19200 || obs_addr[0] !== 15'h0000 || obs_addr[19199] !== 15'h779F) begin
         errors++;
         $display("FAIL clear_span: got n=%0d required 19200 first 0000 last 779f", obs_addr.size());
      end
      checks++;
      if (first_diff() != -1 || obs_gap != 0) begin
         errors++;
         $display("FAIL clear_sequence: got first_diff=%0d gaps=%0d required -1 0", first_diff(), obs_gap);
      end
      checks++;
      if (obs_done_k != 19201 || obs_err_cnt != 0) begin
         errors++;
         $display("FAIL clear_done: got done_k=%0d err_n=%0d required 19201 0", obs_done_k, obs_err_cnt);
      end
   endtask

   task automatic test_clip();
      model_cmd(2'd1, 150, 118, 200, 127, 1'b1);
      run_cmd(2'd1, 8'd150, 7'd118, 8'd200, 7'd127, 1'b1);
      checks++;
      if (obs_timeout || obs_addr.size() != 20 || obs_addr[19] !== 15'h779F) begin
         errors++;
         $display("FAIL clip_count: got n=%0d required 20 last 779f", obs_addr.size());
      end
      checks++;
      if (first_diff() != -1 || obs_done_k != 21) begin
         errors++;
         $display("FAIL clip_sequence: got first_diff=%0d done_k=%0d required -1 21", first_diff(), obs_done_k);
      end
   endtask

   task automatic test_reject();
      logic [1:0] ops[2];
      ops = '{2'd1, 2'd3};
      for (int i = 0; i < 2; i++) begin
         model_cmd(ops[i], 20, 3, 10, 9, 1'b1);
         run_cmd(ops[i], 8'd20, 7'd3, 8'd10, 7'd9, 1'b1);
         checks++;
         if (obs_timeout || obs_addr.size() != 0 || obs_err_k != 1 || obs_err_cnt != 1 ||
             obs_done_cnt != 0 || !obs_ready) begin
            errors++;
            $display("FAIL reject_op%0d: got n=%0d err_k=%0d done_n=%0d ready=%b required 0 1 0 1",
                     ops[i], obs_addr.size(), obs_err_k, obs_done_cnt, obs_ready);
         end
      end
   endtask

   task automatic test_random();
      int r, x0, y0, x1, y1, bad, want_done_k, want_err_k;
      logic [1:0] op;
      logic col;
      for (int i = 0; i < 60; i++) begin
         r  = int'($urandom_range(0, 9));
         op = (r < 2) ? 2'd0 : (r < 8) ? 2'd1 : 2'd3;
         x0 = int'($urandom_range(0, 175));
         if ($urandom_range(0, 7) == 0) x0 = 250;
         y0 = int'($urandom_range(0, 127));
         x1 = x0 + int'($urandom_range(0, 12)) - 2;
         y1 = y0 + int'($urandom_range(0, 6)) - 2;
         if (x1 < 0) x1 = 0;
         if (x1 > 255) x1 = 255;
         if (y1 < 0) y1 = 0;
         if (y1 > 127) y1 = 127;
         if (op == 2'd0) begin
            x1 = int'($urandom_range(0, 255));
            y1 = int'($urandom_range(0, 127));
         end
         col = 1'($urandom);
         model_cmd(op, x0, y0, x1, y1, col);
         run_cmd(op, 8'(x0), 7'(y0), 8'(x1), 7'(y1), col);
         bad = first_diff();
         checks++;
         if (obs_timeout || obs_addr.size() != exp_addr.size() || bad != -1) begin
            errors++;
            $display("FAIL rand%0d_writes: op=%0d (%0d,%0d)-(%0d,%0d) got n=%0d diff_at=%0d required n=%0d",
                     i, op, x0, y0, x1, y1, obs_addr.size(), bad, exp_addr.size());
         end
         want_done_k = exp_err ? 0 : exp_addr.size() + 1;
         want_err_k  = exp_err ? 1 : 0;
         checks++;
         if (obs_done_k != want_done_k || obs_err_k != want_err_k ||
             obs_done_cnt + obs_err_cnt != 1 || !obs_ready) begin
            errors++;
            $display("FAIL rand%0d_status: got done_k=%0d err_k=%0d pulses=%0d ready=%b required %0d %0d 1 1",
                     i, obs_done_k, obs_err_k, obs_done_cnt + obs_err_cnt, obs_ready, want_done_k, want_err_k);
         end
         checks++;
         if (obs_gap != 0 || obs_hold_bad != 0) begin
            errors++;
            $display("FAIL rand%0d_hold: got gaps=%0d hold_violations=%0d required 0 0", i, obs_gap, obs_hold_bad);
         end
      end
   endtask

   task automatic test_reset_midcmd();
      int we_seen;
      @(negedge clk);
      bus.CMD_VALID = 1'b1;
      bus.CMD_OP    = 2'd2;
      @(posedge clk);
      #1;
      bus.CMD_VALID = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (bus.FB_WE !== 1'b1) begin
         errors++;
         $display("FAIL midreset_precondition: got we=%b required 1", bus.FB_WE);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.FB_WE !== 1'b0 || bus.BUSY !== 1'b0 || bus.FB_ADDR !== 15'd0) begin
         errors++;
         $display("FAIL midreset_async: got we=%b busy=%b addr=%h required 0 0 0000",
                  bus.FB_WE, bus.BUSY, bus.FB_ADDR);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (bus.CMD_READY !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready: got %b required 1", bus.CMD_READY);
      end
      we_seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (bus.FB_WE === 1'b1) we_seen++;
      end
      checks++;
      if (we_seen != 0) begin
         errors++;
         $display("FAIL midreset_no_writes: got %0d writes required 0", we_seen);
      end
      last_addr = 15'd0;
      last_data = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_pixel();
      test_rect_small();
      test_reject();
      test_clip();
      test_random();
      test_clear();
      test_reset_midcmd();
      test_pixel();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
